// File: rtl/axis_deadlock_persist_monitor_if.sv
// Handshake bundle between the co-sim stimulus side and the deadlock monitor.
// Clock and reset stay plain ports on the monitor itself.
interface axis_deadlock_persist_monitor_if #(
    parameter int NUM_AXIS       = 4,
    parameter int NUM_SUB        = 3,
    parameter int PERSIST_CYCLES = 16
);
    localparam int CHAN_W = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;
    localparam int CNT_W  = $clog2(PERSIST_CYCLES + 1);

    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_SUB-1:0]  inst_idle_sigs;
    logic [NUM_SUB-1:0]  inst_block_sigs;
    logic                clear;
    logic                block;
    logic [NUM_AXIS-1:0] block_chan;
    logic                block_sub;
    logic [CHAN_W-1:0]   first_chan;
    logic [CNT_W-1:0]    persist_cnt;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  block, block_chan, block_sub, first_chan, persist_cnt
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output block, block_chan, block_sub, first_chan, persist_cnt
    );
endinterface

// File: rtl/axis_deadlock_persist_monitor.sv
// Deadlock monitor for one HLS instance: masked stream stalls or a fully
// blocked/idle sub-instance set must persist before block is raised.
module axis_deadlock_persist_monitor #(
    parameter int                  NUM_AXIS       = 4,
    parameter int                  NUM_SUB        = 3,
    parameter logic [NUM_AXIS-1:0] AXIS_MASK      = 4'b1100,
    parameter int                  PERSIST_CYCLES = 16,
    parameter bit                  STICKY         = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    axis_deadlock_persist_monitor_if.slave mon
);
    localparam int CHAN_W = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;
    localparam int CNT_W  = $clog2(PERSIST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(PERSIST_CYCLES - 1);

    logic [NUM_AXIS-1:0] axis_masked;
    logic                axis_hit;
    logic                sub_hit;
    logic                raw;
    logic                det;

    logic [CNT_W-1:0]    cnt_q;
    logic                block_q;
    logic                block_nxt;
    logic [NUM_AXIS-1:0] chan_q;
    logic                sub_q;
    logic [CHAN_W-1:0]   first_q;

    // Per-channel enable; masked-off channels are tied low here and never
    // reach the counter or the capture path.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXIS; gi++) begin : g_mask
            if (AXIS_MASK[gi]) begin : g_on
                assign axis_masked[gi] = mon.axis_block_sigs[gi];
            end else begin : g_off
                assign axis_masked[gi] = 1'b0;
            end
        end
    endgenerate

    function automatic logic [CHAN_W-1:0] lowest_set(input logic [NUM_AXIS-1:0] v);
        logic [CHAN_W-1:0] r;
        r = '0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (v[i]) r = CHAN_W'(i);
        end
        return r;
    endfunction

    // Sub-instances deadlock only if every one is blocked or idle and at
    // least one is actually blocked (all-idle is a clean finish).
    assign axis_hit = |axis_masked;
    assign sub_hit  = (&(mon.inst_block_sigs | mon.inst_idle_sigs)) & (|mon.inst_block_sigs);
    assign raw      = axis_hit | sub_hit;

    // cnt_q lags one edge, so PRE means this cycle completes the run.
    assign det       = raw & ~mon.clear & ((cnt_q == CNT_PRE) | (cnt_q == CNT_MAX));
    assign block_nxt = STICKY ? (block_q | det) : det;

    always_ff @(posedge clock) begin
        if (reset || mon.clear) begin
            cnt_q <= '0;
        end else if (!raw) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || mon.clear) begin
            block_q <= 1'b0;
        end else begin
            block_q <= block_nxt;
        end
    end

    // Report fields latch only on a fresh detection and survive a
    // non-sticky drop so the report still names the culprit.
    always_ff @(posedge clock) begin
        if (reset || mon.clear) begin
            chan_q  <= '0;
            sub_q   <= 1'b0;
            first_q <= '0;
        end else if (block_nxt && !block_q) begin
            chan_q  <= axis_masked;
            sub_q   <= sub_hit;
            first_q <= lowest_set(axis_masked);
        end
    end

    assign mon.block       = block_q;
    assign mon.block_chan  = chan_q;
    assign mon.block_sub   = sub_q;
    assign mon.first_chan  = first_q;
    assign mon.persist_cnt = cnt_q;
endmodule
